gray_monitor: RTL and testbench
===============================

// Module: gray_monitor
// PURPOSE
//  Downstream checker for the 3-bit Gray up-counter stage (Output/Overflow pair).
//  - Registers each Gray sample and converts it to binary.
//  - Checks that every step is a legal successor; counts wraps and illegal steps.
//  - Holds a fault state until recovery.
//  Sits between the counter and the status/LED logic; pure observer, never back-pressures.
// PARAMETERS
//  CNT_W  8  width of WrapCnt and ErrCnt; both saturate at {CNT_W{1'b1}}
// PORTS
//  Clk        in   1      clock, all logic on posedge
//  Reset      in   1      synchronous, active-low reset (0 = reset, sampled on posedge Clk)
//  Valid      in   1      1 = Gray/OvfIn sampled this cycle; 0 = inputs ignored
//  Gray       in   3      Gray code from counter stage
//  OvfIn      in   1      overflow flag from counter stage (sticky upstream)
//  Bin        out  3      binary of last accepted Gray sample
//  BinValid   out  1      1-cycle pulse, Bin updated this cycle
//  StepErr    out  1      1-cycle pulse on illegal step detected in TRACK
//  ErrSticky  out  1      set on first illegal step; cleared only by Reset
//  WrapCnt    out  CNT_W  legal wraps (Gray 100 -> 000 with OvfIn=1)
//  ErrCnt     out  CNT_W  illegal steps detected
//  State      out  2      00 IDLE, 01 TRACK, 10 FAULT
// BEHAVIOUR
//  Reset (Reset==0 at posedge):
//   - all outputs 0; State=IDLE; internal prev-sample regs 0.
//   - Reset has priority over Valid.
//  Conversion: b2=g2, b1=g2^g1, b0=g2^g1^g0.
//   - Bin registered; BinValid=1 the cycle after each Valid sample (latency 1), in all states.
//  Sequence order (binary 0..7): 000,001,011,010,110,111,101,100.
//  IDLE:
//   - first Valid sample is the reference, no check; -> TRACK.
//   - no sample: stay IDLE.
//  TRACK, per Valid sample (prev = last accepted sample):
//   - HOLD: Gray==prev and OvfIn==prevOvf -> legal, no count.
//   - STEP: bin==prevBin+1, prevBin!=7, OvfIn==prevOvf -> legal.
//   - WRAP: prev Gray 100, new Gray 000, OvfIn=1 -> legal; WrapCnt+1 (saturating).
//   - RESYNC: Gray 000 with OvfIn=0 from any prev -> legal (upstream reset); counters untouched.
//   - anything else -> illegal, including:
//       · OvfIn 0->1 without WRAP
//       · OvfIn 1->0 without RESYNC
//       · skipped or backward codes
//     On illegal: StepErr=1 for one cycle, ErrSticky=1, ErrCnt+1 (saturating), -> FAULT.
//  FAULT:
//   - no step checks, no counting.
//   - Bin/BinValid still track samples; prev regs updated each sample.
//   - Exit per CONFIGURATION.
//  Valid=0: prev regs, counters and State hold; BinValid=0, StepErr=0.
//  Simultaneous Valid and saturated counter: counter holds at max, other effects occur.
// CONFIGURATION
//  GRAY_MON_RESYNC_EN defined:
//   - in FAULT, a Valid sample Gray=000 with OvfIn=0 -> TRACK next cycle.
//   - ErrSticky/ErrCnt are kept.
//  Not defined: FAULT is left only by Reset.
// TESTING
//  1. Reset=0 2 cycles -> all outputs 0, State=00; Reset=1, Valid=1, Gray=000 -> State=01, Bin=000, BinValid=1.
//  2. 8 legal steps 000..100, then 000 with OvfIn=1 -> WrapCnt=1, ErrCnt=0, StepErr never 1.
//  3. From Gray=001 (Bin=1) feed 010 -> StepErr one-cycle pulse, ErrCnt=1, ErrSticky=1, State=10.
//  4. In FAULT feed 000/OvfIn=0 -> with GRAY_MON_RESYNC_EN: State=01, ErrSticky stays 1; without: State stays 10.
//  5. CNT_W=2, 5 wraps -> WrapCnt=3 (saturated); Valid=0 gaps mid-sequence change nothing.
//  6. Reset=0 while in FAULT with ErrCnt=2 -> next cycle all outputs 0, State=00.

Source files
------------

// File: rtl/gray_monitor.sv
// Observer for a 3-bit Gray up-counter: converts, checks successors, counts wraps/errors.
// Optional GRAY_MON_RESYNC_EN lets a 000/OvfIn=0 sample pull FAULT back into TRACK.
module gray_monitor #(
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Valid,
    input  logic [2:0]       Gray,
    input  logic             OvfIn,
    output logic [2:0]       Bin,
    output logic             BinValid,
    output logic             StepErr,
    output logic             ErrSticky,
    output logic [CNT_W-1:0] WrapCnt,
    output logic [CNT_W-1:0] ErrCnt,
    output logic [1:0]       State
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        TRACK = 2'b01,
        FAULT = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t     state_q, state_d;
    logic [2:0] prev_gray;
    logic       prev_ovf;
    logic [2:0] new_bin, prev_bin;
    logic       is_hold, is_step, is_wrap, is_resync, legal;
    logic       illegal, wrap_inc;

    function automatic logic [2:0] g2b(input logic [2:0] g);
        return {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
    endfunction

    assign new_bin  = g2b(Gray);
    assign prev_bin = g2b(prev_gray);

    assign is_hold   = (Gray == prev_gray) && (OvfIn == prev_ovf);
    assign is_step   = (prev_bin != 3'd7) && (new_bin == prev_bin + 3'd1)
                     && (OvfIn == prev_ovf);
    assign is_wrap   = (prev_gray == 3'b100) && (Gray == 3'b000) && OvfIn;
    assign is_resync = (Gray == 3'b000) && !OvfIn;
    assign legal     = is_hold || is_step || is_wrap || is_resync;

    always_comb begin
        state_d  = state_q;
        illegal  = 1'b0;
        wrap_inc = 1'b0;
        if (Valid) begin
            case (state_q)
                IDLE:  state_d = TRACK;
                TRACK: begin
                    if (!legal) begin
                        illegal = 1'b1;
                        state_d = FAULT;
                    end else if (is_wrap) begin
                        wrap_inc = 1'b1;
                    end
                end
                FAULT: begin
`ifdef GRAY_MON_RESYNC_EN
                    if (is_resync) state_d = TRACK;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q   <= IDLE;
            prev_gray <= 3'b000;
            prev_ovf  <= 1'b0;
            BinValid  <= 1'b0;
            StepErr   <= 1'b0;
            ErrSticky <= 1'b0;
            WrapCnt   <= '0;
            ErrCnt    <= '0;
        end else begin
            state_q  <= state_d;
            BinValid <= Valid;
            StepErr  <= illegal;
            if (Valid) begin
                prev_gray <= Gray;
                prev_ovf  <= OvfIn;
            end
            if (illegal) begin
                ErrSticky <= 1'b1;
                if (ErrCnt != CNT_MAX) ErrCnt <= ErrCnt + 1'b1;
            end
            if (wrap_inc && WrapCnt != CNT_MAX) WrapCnt <= WrapCnt + 1'b1;
        end
    end

    // Bin is a pure function of the registered sample, so it is already latency 1
    assign Bin   = prev_bin;
    assign State = state_q;

endmodule

// File: tb/tb_gray_monitor.sv
// Directed, table-driven check of gray_monitor with CNT_W=2 so saturation is reachable.
module tb_gray_monitor;

    localparam int W = 2;
`ifdef GRAY_MON_RESYNC_EN
    localparam bit RES = 1'b1;
`else
    localparam bit RES = 1'b0;
`endif

    logic         Clk = 1'b0;
    logic         Reset, Valid, OvfIn;
    logic [2:0]   Gray;
    logic [2:0]   Bin;
    logic         BinValid, StepErr, ErrSticky;
    logic [W-1:0] WrapCnt, ErrCnt;
    logic [1:0]   State;

    gray_monitor #(.CNT_W(W)) dut (
        .Clk(Clk), .Reset(Reset), .Valid(Valid), .Gray(Gray), .OvfIn(OvfIn),
        .Bin(Bin), .BinValid(BinValid), .StepErr(StepErr), .ErrSticky(ErrSticky),
        .WrapCnt(WrapCnt), .ErrCnt(ErrCnt), .State(State)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       r, v;
        logic [2:0] g;
        logic       o;
        logic [2:0] bin;
        logic       bv, se, es;
        logic [1:0] wc, ec, st;
    } vec_t;

    vec_t vecs[$];
    int total = 0;
    int bad   = 0;

    function automatic logic [2:0] gc(input int i);
        logic [2:0] b;
        b = 3'(i);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [1:0] sat(input int n);
        return (n > 3) ? 2'd3 : 2'(n);
    endfunction

    function automatic void add(input logic r, v, input logic [2:0] g,
                                input logic o, input logic [2:0] bin,
                                input logic bv, se, es,
                                input logic [1:0] wc, ec, st);
        vec_t x;
        x.r = r; x.v = v; x.g = g; x.o = o; x.bin = bin;
        x.bv = bv; x.se = se; x.es = es; x.wc = wc; x.ec = ec; x.st = st;
        vecs.push_back(x);
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row %0d: got %0h want %0h", nm, idx, act, exp);
        end
    endtask

    task automatic run_row(input int i);
        Reset = vecs[i].r; Valid = vecs[i].v;
        Gray = vecs[i].g;  OvfIn = vecs[i].o;
        @(posedge Clk); #1;
        chk("Bin", i, 8'(Bin), 8'(vecs[i].bin));
        chk("BinValid", i, 8'(BinValid), 8'(vecs[i].bv));
        chk("StepErr", i, 8'(StepErr), 8'(vecs[i].se));
        chk("ErrSticky", i, 8'(ErrSticky), 8'(vecs[i].es));
        chk("WrapCnt", i, 8'(WrapCnt), 8'(vecs[i].wc));
        chk("ErrCnt", i, 8'(ErrCnt), 8'(vecs[i].ec));
        chk("State", i, 8'(State), 8'(vecs[i].st));
    endtask

    initial begin
        Reset = 1'b0; Valid = 1'b0; Gray = 3'b000; OvfIn = 1'b0;
        // reset, reset priority over Valid, idle with no sample
        add(0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 3'b011, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 3'b101, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 3'b000, 0, 0, 1, 0, 0, 0, 0, 1);
        for (int i = 1; i < 8; i++) begin
            add(1, 1, gc(i), 0, 3'(i), 1, 0, 0, 0, 0, 1);
            if (i == 4) add(1, 0, 3'b011, 1, 3'd4, 0, 0, 0, 0, 0, 1);
            if (i == 5) add(1, 1, gc(5), 0, 3'd5, 1, 0, 0, 0, 0, 1);
        end
        add(1, 1, 3'b000, 1, 0, 1, 0, 0, 1, 0, 1);
        for (int w = 2; w <= 5; w++) begin
            for (int i = 1; i < 8; i++)
                add(1, 1, gc(i), 1, 3'(i), 1, 0, 0, sat(w - 1), 0, 1);
            add(1, 1, 3'b000, 1, 0, 1, 0, 0, sat(w), 0, 1);
        end
        // resync in TRACK, then a skip from 001 to 010
        add(1, 1, 3'b000, 0, 0, 1, 0, 0, 3, 0, 1);
        add(1, 1, 3'b001, 0, 1, 1, 0, 0, 3, 0, 1);
        add(1, 1, 3'b010, 0, 3, 1, 1, 1, 3, 1, 2);
        add(1, 1, 3'b110, 0, 4, 1, 0, 1, 3, 1, 2);
        add(1, 0, 3'b000, 0, 4, 0, 0, 1, 3, 1, 2);
        add(1, 1, 3'b000, 0, 0, 1, 0, 1, 3, 1, RES ? 2'd1 : 2'd2);
        add(1, 1, 3'b001, 1, 1, 1, RES, 1, 3, RES ? 2'd2 : 2'd1, 2);
        add(0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
        // OvfIn 0->1 without wrap (also backward)
        add(1, 1, 3'b000, 0, 0, 1, 0, 0, 0, 0, 1);
        add(1, 1, 3'b001, 0, 1, 1, 0, 0, 0, 0, 1);
        add(1, 1, 3'b000, 1, 0, 1, 1, 1, 0, 1, 2);
        add(0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
        // backward step
        add(1, 1, 3'b011, 0, 2, 1, 0, 0, 0, 0, 1);
        add(1, 1, 3'b001, 0, 1, 1, 1, 1, 0, 1, 2);
        add(0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
        // resync from 100/ovf=1, then OvfIn 0->1 on a step
        add(1, 1, 3'b100, 1, 7, 1, 0, 0, 0, 0, 1);
        add(1, 1, 3'b000, 0, 0, 1, 0, 0, 0, 0, 1);
        add(1, 1, 3'b001, 1, 1, 1, 1, 1, 0, 1, 2);
        add(0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
        // OvfIn 1->0 on a step
        add(1, 1, 3'b001, 1, 1, 1, 0, 0, 0, 0, 1);
        add(1, 1, 3'b011, 0, 2, 1, 1, 1, 0, 1, 2);

        for (int i = 0; i < vecs.size(); i++) run_row(i);

        // Valid=0 gap while in FAULT: nothing moves
        for (int k = 0; k < 3; k++) begin
            Reset = 1'b1; Valid = 1'b0;
            Gray = 3'($urandom_range(7)); OvfIn = 1'($urandom_range(1));
            @(posedge Clk); #1;
            chk("gap State", 1000 + k, 8'(State), 8'd2);
            chk("gap ErrCnt", 1000 + k, 8'(ErrCnt), 8'd1);
            chk("gap Bin", 1000 + k, 8'(Bin), 8'd2);
            chk("gap BinValid", 1000 + k, 8'(BinValid), 8'd0);
            chk("gap StepErr", 1000 + k, 8'(StepErr), 8'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
